// File: rtl/mode_counter_pkg.sv
// Shared types and constants for the mode counter board top: mode codes,
// seven-segment table and default timing.
package mode_counter_pkg;

    localparam int unsigned CLK_HZ_DEF       = 100_000_000;
    localparam int unsigned DEBOUNCE_CYC_DEF = 1_000_000;
    localparam int unsigned TICK_CYC_DEF     = 100_000;
    localparam int unsigned SCAN_CYC_DEF     = 100_000;

    localparam int unsigned NUM_BTN = 3;
    localparam int unsigned SW_W    = 8;
    localparam int unsigned LED_W   = 16;
    localparam int unsigned CNT_W   = 14;
    localparam int unsigned CNT_MAX = 9999;

    // Encoding doubles as the LED pattern on led[15:13].
    typedef enum logic [2:0] {
        MODE_IDLE = 3'b000,
        MODE_UP   = 3'b001,
        MODE_DOWN = 3'b010,
        MODE_SW   = 3'b100
    } mode_e;

    // Active-low cathodes {dp,g..a}, indexed by hex value; dp always off.
    localparam logic [15:0][7:0] SEG_TABLE = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    function automatic logic [7:0] seg_encode(input logic [3:0] i_hex);
        return SEG_TABLE[i_hex];
    endfunction

endpackage

// File: rtl/mode_counter_top_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter and a one-cycle
// pulse on the debounced rising edge.
module btn_debounce
    import mode_counter_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_pulse
);

    localparam int unsigned DB_CNT_W = $clog2(DEBOUNCE_CYC + 1);

    logic [1:0]          r_sync;
    logic [DB_CNT_W-1:0] r_cnt;
    logic                r_clean;
    logic                r_pulse;
    logic                w_sync;
    logic                w_done;

    assign w_sync  = r_sync[1];
    assign w_done  = (r_cnt == DB_CNT_W'(DEBOUNCE_CYC - 1));
    assign o_pulse = r_pulse;

    // Count restarts whenever the synced level falls back to the clean level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_clean <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_raw};
            r_pulse <= 1'b0;
            if (w_sync == r_clean) begin
                r_cnt <= '0;
            end else if (w_done) begin
                r_cnt   <= '0;
                r_clean <= w_sync;
                r_pulse <= w_sync;
            end else begin
                r_cnt <= r_cnt + DB_CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mode_counter_top.sv
// Board top: debounced buttons step a 4-mode FSM that counts 0..9999 up/down
// or shows the switches on a multiplexed 4-digit seven-segment display.
module mode_counter_top
    import mode_counter_pkg::*;
#(
    parameter int unsigned CLK_HZ       = CLK_HZ_DEF,
    parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int unsigned TICK_CYC     = TICK_CYC_DEF,
    parameter int unsigned SCAN_CYC     = SCAN_CYC_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn,
    input  logic [SW_W-1:0]    sw,
    output logic [LED_W-1:0]   led,
    output logic [7:0]         seg,
    output logic [3:0]         an
);

    // Dividers are sized to hold up to one second of clock cycles.
    localparam int unsigned DIV_W = $clog2(CLK_HZ + 1);

    logic [NUM_BTN-1:0] w_press;
    logic [SW_W-1:0]    r_sw_meta;
    logic [SW_W-1:0]    r_sw_sync;
    mode_e              r_mode;
    mode_e              w_mode_nxt;
    logic [CNT_W-1:0]   r_count;
    logic               r_run;
    logic [DIV_W-1:0]   r_tick_cnt;
    logic [DIV_W-1:0]   r_scan_cnt;
    logic [1:0]         r_scan_idx;
    logic               w_tick;
    logic               w_scan;
    logic [3:0]         w_d3, w_d2, w_d1, w_d0;
    logic [3:0]         w_digit;
    logic [LED_W-1:0]   r_led;
    logic [7:0]         r_seg;
    logic [3:0]         r_an;

    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
        btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
            .clk    (clk),
            .rst_n  (reset),
            .i_raw  (btn[gi]),
            .o_pulse(w_press[gi])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sw_meta <= '0;
            r_sw_sync <= '0;
        end else begin
            r_sw_meta <= sw;
            r_sw_sync <= r_sw_meta;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_mode <= MODE_IDLE;
        else        r_mode <= w_mode_nxt;
    end

    always_comb begin
        w_mode_nxt = r_mode;
        if (w_press[0]) begin
            case (r_mode)
                MODE_IDLE: w_mode_nxt = MODE_UP;
                MODE_UP:   w_mode_nxt = MODE_DOWN;
                MODE_DOWN: w_mode_nxt = MODE_SW;
                default:   w_mode_nxt = MODE_IDLE;
            endcase
        end
    end

    assign w_tick = (r_tick_cnt == DIV_W'(TICK_CYC - 1));
    assign w_scan = (r_scan_cnt == DIV_W'(SCAN_CYC - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tick_cnt <= '0;
            r_scan_cnt <= '0;
            r_scan_idx <= '0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + DIV_W'(1);
            r_scan_cnt <= w_scan ? '0 : r_scan_cnt + DIV_W'(1);
            if (w_scan) r_scan_idx <= r_scan_idx + 2'd1;
        end
    end

    // Clear wins over a same-cycle tick; run only matters in UP/DOWN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            r_run   <= 1'b1;
        end else begin
            if (w_press[2]) r_run <= ~r_run;
            if (w_press[1]) begin
                r_count <= '0;
            end else if (w_tick && r_run) begin
                if (r_mode == MODE_UP)
                    r_count <= (r_count == CNT_W'(CNT_MAX)) ? '0 : r_count + CNT_W'(1);
                else if (r_mode == MODE_DOWN)
                    r_count <= (r_count == '0) ? CNT_W'(CNT_MAX) : r_count - CNT_W'(1);
            end
        end
    end

    assign w_d3 = 4'(r_count / CNT_W'(1000));
    assign w_d2 = 4'((r_count / CNT_W'(100)) % CNT_W'(10));
    assign w_d1 = 4'((r_count / CNT_W'(10)) % CNT_W'(10));
    assign w_d0 = 4'(r_count % CNT_W'(10));

    always_comb begin
        w_digit = '0;
        if (r_mode == MODE_SW) begin
            case (r_scan_idx)
                2'd0:    w_digit = r_sw_sync[3:0];
                2'd1:    w_digit = r_sw_sync[7:4];
                default: w_digit = '0;
            endcase
        end else begin
            case (r_scan_idx)
                2'd0:    w_digit = w_d0;
                2'd1:    w_digit = w_d1;
                2'd2:    w_digit = w_d2;
                default: w_digit = w_d3;
            endcase
        end
    end

    // LEDs follow the next mode so they move together with the mode register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_led <= '0;
            r_seg <= SEG_TABLE[0];
            r_an  <= 4'b1110;
        end else begin
            r_led <= {w_mode_nxt, 5'b0, (w_mode_nxt == MODE_SW) ? r_sw_sync : 8'h00};
            r_seg <= seg_encode(w_digit);
            r_an  <= ~(4'b0001 << r_scan_idx);
        end
    end

    assign led = r_led;
    assign seg = r_seg;
    assign an  = r_an;

endmodule

// File: tb/tb_mode_counter_top.sv
// Scoreboard bench for mode_counter_top with shortened timing constants.
module tb_mode_counter_top;

    localparam int unsigned DEB  = 4;
    localparam int unsigned TICK = 10;
    localparam int unsigned SCAN = 5;

    localparam logic [7:0] S0 = 8'hC0, S1 = 8'hF9, S2 = 8'hA4, S3 = 8'hB0;
    localparam logic [7:0] S4 = 8'h99, S5 = 8'h92, S8 = 8'h80, S9 = 8'h90;
    localparam logic [7:0] SA = 8'h88;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  btn   = 3'b000;
    logic [7:0]  sw    = 8'h00;
    logic [15:0] led;
    logic [7:0]  seg;
    logic [3:0]  an;

    typedef struct {
        logic [3:0] an;
        logic [7:0] seg;
        string      tag;
    } disp_t;

    logic [15:0] led_q[$];
    string       led_tag_q[$];
    disp_t       disp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;

    mode_counter_top #(
        .CLK_HZ      (100_000_000),
        .DEBOUNCE_CYC(DEB),
        .TICK_CYC    (TICK),
        .SCAN_CYC    (SCAN)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .btn  (btn),
        .sw   (sw),
        .led  (led),
        .seg  (seg),
        .an   (an)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int b);
        btn[b] = 1'b1;
        cycles(DEB + 4);
        btn[b] = 1'b0;
        cycles(DEB + 6);
    endtask

    // Run exactly k ticks: run-on and run-off presses are k*TICK cycles apart.
    task automatic run_ticks(input int k);
        int t0;
        t0 = cyc;
        press(2);
        while (cyc < t0 + k * int'(TICK)) @(negedge clk);
        press(2);
    endtask

    task automatic expect_led(input logic [15:0] v, input string tag);
        led_q.push_back(v);
        led_tag_q.push_back(tag);
    endtask

    task automatic expect_digits(input logic [7:0] s3, input logic [7:0] s2,
                                 input logic [7:0] s1, input logic [7:0] s0,
                                 input string tag);
        disp_q.push_back('{4'b1110, s0, tag});
        disp_q.push_back('{4'b1101, s1, tag});
        disp_q.push_back('{4'b1011, s2, tag});
        disp_q.push_back('{4'b0111, s3, tag});
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((led_q.size() != 0 || disp_q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (led_q.size() != 0 || disp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_%s pending led=%0d disp=%0d required 0 0",
                     tag, led_q.size(), disp_q.size());
            led_q.delete();
            led_tag_q.delete();
            disp_q.delete();
        end
    endtask

    // LED monitor: every change of led must match the next expected value.
    initial begin : mon_led
        logic [15:0] last;
        logic [15:0] e;
        string       t;
        @(posedge reset);
        @(negedge clk);
        checks++;
        e = led_q.pop_front();
        t = led_tag_q.pop_front();
        if (led !== e) begin
            errors++;
            $display("FAIL led_%s got %h required %h", t, led, e);
        end
        last = led;
        forever begin
            @(negedge clk);
            if (led !== last) begin
                checks++;
                if (led_q.size() == 0) begin
                    errors++;
                    $display("FAIL led_unexpected got %h required %h", led, last);
                end else begin
                    e = led_q.pop_front();
                    t = led_tag_q.pop_front();
                    if (led !== e) begin
                        errors++;
                        $display("FAIL led_%s got %h required %h", t, led, e);
                    end
                end
                last = led;
            end
        end
    end

    // Display monitor: each fresh digit strobe checks rotation and, when awaited, its segments.
    initial begin : mon_disp
        logic [3:0] prev_an;
        logic [3:0] exp_an;
        disp_t      d;
        int         idx;
        @(posedge reset);
        @(negedge clk);
        d = disp_q.pop_front();
        checks++;
        if (an !== d.an || seg !== d.seg) begin
            errors++;
            $display("FAIL disp_%s got an=%b seg=%h required an=%b seg=%h",
                     d.tag, an, seg, d.an, d.seg);
        end
        prev_an = an;
        idx     = 0;
        forever begin
            @(negedge clk);
            if (an !== prev_an) begin
                idx    = (idx + 1) % 4;
                exp_an = ~(4'b0001 << idx);
                checks++;
                if (an !== exp_an) begin
                    errors++;
                    $display("FAIL an_rotation got %b required %b", an, exp_an);
                end
                if (disp_q.size() != 0 && an === disp_q[0].an) begin
                    d = disp_q.pop_front();
                    checks++;
                    if (seg !== d.seg) begin
                        errors++;
                        $display("FAIL disp_%s an=%b got seg=%h required %h",
                                 d.tag, an, seg, d.seg);
                    end
                end
                prev_an = an;
            end
        end
    end

    initial begin : watchdog
        #600_000;
        $display("FAIL watchdog simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        expect_led(16'h0000, "reset");
        disp_q.push_back('{4'b1110, S0, "reset"});
        #100 reset = 1'b1;
        cycles(2);
        drain("reset");

        expect_digits(S0, S0, S0, S0, "idle0");
        drain("idle0");
        cycles(40);

        expect_led(16'h2000, "mode_up");
        btn[0] = 1'b1; cycles(1);
        btn[0] = 1'b0; cycles(2);
        btn[0] = 1'b1; cycles(2);
        btn[0] = 1'b0; cycles(2);
        press(0);
        drain("mode_up");
        cycles(100);

        press(2);
        press(1);
        expect_digits(S0, S0, S0, S0, "up_clear");
        drain("up_clear");
        run_ticks(1234);
        expect_digits(S1, S2, S3, S4, "up_1234");
        drain("up_1234");

        expect_led(16'h4000, "mode_down");
        press(0);
        drain("mode_down");
        expect_digits(S1, S2, S3, S4, "down_hold");
        drain("down_hold");
        run_ticks(3);
        expect_digits(S1, S2, S3, S1, "down_1231");
        drain("down_1231");
        press(1);
        expect_digits(S0, S0, S0, S0, "down_clear");
        drain("down_clear");
        run_ticks(2);
        expect_digits(S9, S9, S9, S8, "down_wrap");
        drain("down_wrap");

        sw = 8'h55;
        cycles(5);
        expect_led(16'h8055, "mode_sw");
        press(0);
        drain("mode_sw");
        expect_digits(S0, S0, S5, S5, "sw55");
        drain("sw55");
        expect_led(16'h80AA, "sw_aa");
        sw = 8'hAA;
        drain("sw_aa");
        expect_digits(S0, S0, SA, SA, "swaa");
        drain("swaa");
        run_ticks(3);

        expect_led(16'h0000, "mode_idle");
        press(0);
        drain("mode_idle");
        expect_digits(S9, S9, S9, S8, "idle_hold");
        drain("idle_hold");

        expect_led(16'h2000, "mode_up2");
        press(0);
        drain("mode_up2");
        run_ticks(3);
        expect_digits(S0, S0, S0, S1, "up_wrap");
        drain("up_wrap");

        cycles(20);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
